pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Data-hazard controller for a short in-order pipeline: tracks in-flight writers,
// selects forwarding sources, and inserts a one-cycle bubble on load-use or flag-ordering hazards.
module pipeline_hazard_ctrl #(
    parameter int AW     = 5,
    parameter int STAGES = 3,
    parameter int ZREG   = 31,
    parameter int CW     = 32,
    localparam int SW    = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rn,
    input  logic [AW-1:0]     id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_sets_flags,
    input  logic              id_uses_flags,
    input  logic              br_taken,
    output logic [SW-1:0]     fwd_a,
    output logic [SW-1:0]     fwd_b,
    output logic              fwd_flag,
    output logic              stall,
    output logic              issue,
    output logic              flush_if,
    output logic [STAGES-1:0] stage_valid,
    output logic [CW-1:0]     stall_count
);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic          regWrite;
        logic          isLoad;
        logic          setsFlags;
    } entry_t;

    logic [STAGES:1] entValid;
    entry_t          entData [1:STAGES];
    logic [STAGES:1] matchA;
    logic [STAGES:1] matchB;
    logic            olderSetter;
    logic            loadUse;
    logic            flagHazard;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic srcMatch(input logic v, input entry_t e,
                                      input logic [AW-1:0] src, input logic useSrc);
        return v && e.regWrite && (e.rd == src) && (src != AW'(ZREG)) && useSrc;
    endfunction

    always_comb begin
        matchA      = '0;
        matchB      = '0;
        olderSetter = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            matchA[k] = srcMatch(entValid[k], entData[k], id_rn, id_use_rn);
            matchB[k] = srcMatch(entValid[k], entData[k], id_rm, id_use_rm);
            if (k >= 2) begin
                olderSetter = olderSetter | (entValid[k] & entData[k].setsFlags);
            end
        end
    end

    // A load in entry 1 has no data yet: consumers of it, or flag readers that would
    // otherwise see stale flags past it, wait one cycle.
    assign loadUse    = id_valid & entValid[1] & entData[1].isLoad & (matchA[1] | matchB[1]);
    assign flagHazard = id_valid & id_uses_flags & entValid[1] & entData[1].isLoad & olderSetter;
    assign stall      = loadUse | flagHazard;
    assign issue      = id_valid & ~stall;
    assign flush_if   = reset & br_taken & issue;
    assign fwd_flag   = id_uses_flags & entValid[1] & entData[1].setsFlags;
    assign stage_valid = entValid;

    // Scan oldest to youngest so the youngest producer overrides.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (matchA[k] && !(k == 1 && entData[1].isLoad)) begin
                fwd_a = SW'(k);
            end
            if (matchB[k] && !(k == 1 && entData[1].isLoad)) begin
                fwd_b = SW'(k);
            end
        end
    end

    // Stage boundary: scoreboard valid bits and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entValid    <= '0;
            stall_count <= '0;
        end else begin
            entValid <= {entValid[STAGES-1:1], issue};
            if (stall) begin
                stall_count <= satInc(stall_count);
            end
        end
    end

    // Stage boundary: scoreboard payload, qualified by entValid
    always_ff @(posedge clk) begin
        entData[1] <= '{rd: id_rd, regWrite: id_reg_write, isLoad: id_is_load,
                        setsFlags: id_sets_flags};
        for (int k = 2; k <= STAGES; k++) begin
            entData[k] <= entData[k-1];
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: an in-flight instruction list models the
// pipeline, every cycle is compared against it, and literal checks pin the key scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int AW     = 5;
    localparam int STAGES = 3;
    localparam int ZREG   = 31;
    localparam int CW     = 4;
    localparam int SW     = $clog2(STAGES + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              idValid, idUseRn, idUseRm, idRegWrite, idIsLoad, idSetsFlags, idUsesFlags, brTaken;
    logic [AW-1:0]     idRn, idRm, idRd;
    logic [SW-1:0]     fwdA, fwdB;
    logic              fwdFlag, stall, issue, flushIf;
    logic [STAGES-1:0] stageValid;
    logic [CW-1:0]     stallCount;

    pipeline_hazard_ctrl #(.AW(AW), .STAGES(STAGES), .ZREG(ZREG), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(idValid), .id_rn(idRn), .id_rm(idRm), .id_use_rn(idUseRn), .id_use_rm(idUseRm),
        .id_rd(idRd), .id_reg_write(idRegWrite), .id_is_load(idIsLoad),
        .id_sets_flags(idSetsFlags), .id_uses_flags(idUsesFlags), .br_taken(brTaken),
        .fwd_a(fwdA), .fwd_b(fwdB), .fwd_flag(fwdFlag), .stall(stall), .issue(issue),
        .flush_if(flushIf), .stage_valid(stageValid), .stall_count(stallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
        bit sf;
    } ins_t;

    ins_t pipe[$];   // pipe[0] is the youngest in-flight instruction
    int   mCount;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void modelClear();
        ins_t b;
        b = '{v: 0, rd: 0, rw: 0, ld: 0, sf: 0};
        pipe.delete();
        for (int k = 0; k < STAGES; k++) pipe.push_back(b);
        mCount = 0;
    endfunction

    function automatic int producer(input int src, input bit u);
        if (!u || src == ZREG) return 0;
        for (int k = 0; k < STAGES; k++) begin
            if (pipe[k].v && pipe[k].rw && pipe[k].rd == src) begin
                if (k == 0 && pipe[0].ld) continue;
                return k + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit expStall();
        bit dep, older;
        dep = (idUseRn && int'(idRn) == pipe[0].rd && int'(idRn) != ZREG) ||
              (idUseRm && int'(idRm) == pipe[0].rd && int'(idRm) != ZREG);
        older = 0;
        for (int k = 1; k < STAGES; k++) older = older || (pipe[k].v && pipe[k].sf);
        return idValid && pipe[0].v && pipe[0].ld && ((pipe[0].rw && dep) || (idUsesFlags && older));
    endfunction

    function automatic void modelStep();
        bit   s;
        ins_t n;
        s = expStall();
        if (s && mCount < (1 << CW) - 1) mCount++;
        if (idValid && !s) n = '{v: 1, rd: int'(idRd), rw: idRegWrite, ld: idIsLoad, sf: idSetsFlags};
        else               n = '{v: 0, rd: 0, rw: 0, ld: 0, sf: 0};
        void'(pipe.pop_back());
        pipe.push_front(n);
    endfunction

    // Every-cycle comparison against the model
    initial begin
        forever begin
            bit s, iss;
            logic [STAGES-1:0] sv;
            @(negedge clk);
            s   = expStall();
            iss = idValid && !s;
            for (int k = 0; k < STAGES; k++) sv[k] = pipe[k].v;
            chk("stall", stall, s);
            chk("issue", issue, iss);
            chk("flush_if", flushIf, reset && brTaken && iss);
            chk("fwd_a", fwdA, producer(int'(idRn), idUseRn));
            chk("fwd_b", fwdB, producer(int'(idRm), idUseRm));
            chk("fwd_flag", fwdFlag, idUsesFlags && pipe[0].v && pipe[0].sf);
            chk("stage_valid", stageValid, sv);
            chk("stall_count", stallCount, mCount);
        end
    end

    task automatic cyc(input bit v, input int rn, input int rm, input bit urn, input bit urm,
                       input int rd, input bit rw, input bit ld, input bit sf, input bit uf, input bit br);
        @(posedge clk);
        if (reset) modelStep();
        #2;
        idValid = v; idRn = AW'(rn); idRm = AW'(rm); idUseRn = urn; idUseRm = urm;
        idRd = AW'(rd); idRegWrite = rw; idIsLoad = ld; idSetsFlags = sf;
        idUsesFlags = uf; brTaken = br;
        @(negedge clk);
        #1;
    endtask

    task automatic alu(input int rd, input int rn, input int rm);
        cyc(1, rn, rm, 1, 1, rd, 1, 0, 0, 0, 0);
    endtask

    task automatic ldur(input int rd, input int rn);
        cyc(1, rn, 0, 1, 0, rd, 1, 1, 0, 0, 0);
    endtask

    task automatic bub();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        idValid = 0; idRn = '0; idRm = '0; idUseRn = 0; idUseRm = 0; idRd = '0;
        idRegWrite = 0; idIsLoad = 0; idSetsFlags = 0; idUsesFlags = 0; brTaken = 0;
        modelClear();

        // Reset: issue follows id_valid, everything else quiet
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_rst_issue", issue, 1);
        chk("lit_rst_flush", flushIf, 0);
        chk("lit_rst_stall", stall, 0);
        chk("lit_rst_stage_valid", stageValid, 0);
        chk("lit_rst_count", stallCount, 0);
        @(posedge clk);
        #2;
        reset = 1'b1; idValid = 0; brTaken = 0;
        @(negedge clk);
        #1;

        // Forwarding distance 1, then distance 2 across a bubble
        alu(1, 4, 5);
        chk("lit_empty_fwd_a", fwdA, 0);
        alu(7, 1, 6);
        chk("lit_fwd1_a", fwdA, 1);
        chk("lit_fwd1_b", fwdB, 0);
        alu(1, 4, 5);
        bub();
        alu(9, 1, 6);
        chk("lit_fwd2_a", fwdA, 2);

        // Load-use: one stall, then forward from stage 2
        ldur(2, 8);
        chk("lit_ld_nostall", stall, 0);
        alu(10, 11, 2);
        chk("lit_lu_stall", stall, 1);
        chk("lit_lu_issue", issue, 0);
        chk("lit_lu_fwd_b", fwdB, 0);
        alu(10, 11, 2);
        chk("lit_lu2_stall", stall, 0);
        chk("lit_lu2_issue", issue, 1);
        chk("lit_lu2_fwd_b", fwdB, 2);
        chk("lit_lu2_count", stallCount, 1);

        // Youngest producer wins; both operands from the same stage
        alu(3, 4, 5);
        alu(3, 6, 6);
        alu(13, 3, 12);
        chk("lit_young_a", fwdA, 1);
        chk("lit_young_b", fwdB, 0);
        alu(14, 3, 3);
        chk("lit_same_a", fwdA, 2);
        chk("lit_same_b", fwdB, 2);

        // Zero register never forwards or stalls
        alu(31, 4, 5);
        alu(14, 31, 31);
        chk("lit_zr_a", fwdA, 0);
        chk("lit_zr_b", fwdB, 0);
        ldur(31, 4);
        alu(14, 31, 4);
        chk("lit_zrld_stall", stall, 0);
        chk("lit_zrld_a", fwdA, 0);

        // Flags forwarding and branch flush, then branch under load-use stall
        cyc(1, 4, 5, 1, 1, 15, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("lit_bcond_flag", fwdFlag, 1);
        chk("lit_bcond_flush", flushIf, 1);
        chk("lit_bcond_stall", stall, 0);
        ldur(16, 4);
        cyc(1, 16, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_brstall_stall", stall, 1);
        chk("lit_brstall_flush", flushIf, 0);
        cyc(1, 16, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_brgo_fwd_a", fwdA, 2);
        chk("lit_brgo_flush", flushIf, 1);

        // Flag reader behind a load with an older flag setter
        cyc(1, 4, 5, 1, 1, 17, 1, 0, 1, 0, 0);
        ldur(18, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("lit_flaghaz_stall", stall, 1);
        chk("lit_flaghaz_flag", fwdFlag, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("lit_flagok_stall", stall, 0);
        chk("lit_flagok_count", stallCount, 3);

        // Drive the counter into saturation
        repeat (26) ldur(2, 2);
        chk("lit_sat_reach", stallCount, 15);
        ldur(2, 2);
        ldur(2, 2);
        chk("lit_sat_stall", stall, 1);
        bub();
        chk("lit_sat_hold", stallCount, 15);

        // Reset asserted in the middle of a stall
        ldur(20, 4);
        alu(21, 20, 5);
        chk("lit_pre_rst_stall", stall, 1);
        reset = 1'b0;
        modelClear();
        #1;
        chk("lit_mid_rst_stall", stall, 0);
        chk("lit_mid_rst_fwd_a", fwdA, 0);
        chk("lit_mid_rst_fwd_b", fwdB, 0);
        chk("lit_mid_rst_flag", fwdFlag, 0);
        chk("lit_mid_rst_flush", flushIf, 0);
        chk("lit_mid_rst_sv", stageValid, 0);
        chk("lit_mid_rst_count", stallCount, 0);
        chk("lit_mid_rst_issue", issue, 1);
        cyc(1, 20, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        chk("lit_rst_br_flush", flushIf, 0);
        @(posedge clk);
        #2;
        reset = 1'b1; idValid = 0; brTaken = 0; idUsesFlags = 0;
        @(negedge clk);
        #1;
        chk("lit_post_rst_sv", stageValid, 0);
        alu(1, 4, 5);
        alu(7, 1, 6);
        chk("lit_post_rst_fwd", fwdA, 1);
        bub();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
